// File: rtl/intf_rr_pkg.sv
// Shared types and helpers for the request/response responder.
package intf_rr_pkg;

    localparam int W_DEF     = 4;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wrapping add, with the result masked to the low w bits.
    function automatic logic [31:0] next_b(input logic [31:0] a,
                                           input logic [31:0] offset,
                                           input int          w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a + offset) & mask;
    endfunction

endpackage

// File: rtl/rr_fifo.sv
// Synchronous request FIFO.
// The head entry is read straight from the array, so it can be popped into a work register on the same edge.
module rr_fifo
    import intf_rr_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/intf_rr_responder.sv
// Responder end of the request/response interface: FIFO-buffered requests, fixed-latency req_a + OFFSET responses.
// Define INTF_RR_PARITY_EN to add the rsp_par output (XOR reduction of rsp_b).
module intf_rr_responder
    import intf_rr_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = 2,
    parameter int OFFSET  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [W-1:0]                req_a,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [W-1:0]                rsp_b,
`ifdef INTF_RR_PARITY_EN
    output logic                        rsp_par,
`endif
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        busy
);

    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    work_q, work_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_b_q, rsp_b_d;
    logic [W-1:0]    sum;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [W-1:0]    fifo_dout;
`ifdef INTF_RR_PARITY_EN
    logic            rsp_par_q, rsp_par_d;
`endif

    rr_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .pop   (fifo_pop),
        .din   (req_a),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign req_ready = !fifo_full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_b     = rsp_b_q;
    assign busy      = (state_q != IDLE);
    assign sum       = W'(next_b(32'(work_q), OFFSET, W));
`ifdef INTF_RR_PARITY_EN
    assign rsp_par   = rsp_par_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        rsp_valid_d = rsp_valid_q;
        rsp_b_d     = rsp_b_q;
        fifo_pop    = 1'b0;
`ifdef INTF_RR_PARITY_EN
        rsp_par_d   = rsp_par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    work_d   = fifo_dout;
                    cnt_d    = CNTW'(LATENCY - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_b_d     = sum;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef INTF_RR_PARITY_EN
                    rsp_par_d   = ^sum;
`endif
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                // A queued request starts on the handshake edge itself.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        work_d   = fifo_dout;
                        cnt_d    = CNTW'(LATENCY - 1);
                        state_d  = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_b_q     <= '0;
`ifdef INTF_RR_PARITY_EN
            rsp_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_b_q     <= rsp_b_d;
`ifdef INTF_RR_PARITY_EN
            rsp_par_q   <= rsp_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_intf_rr_responder.sv
// Directed self-checking bench for intf_rr_responder (W=4, DEPTH=4, LATENCY=2, OFFSET=3).
module tb_intf_rr_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_b;
    logic [2:0] occupancy;
    logic       busy;
`ifdef INTF_RR_PARITY_EN
    logic       rsp_par;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    intf_rr_responder #(.W(4), .DEPTH(4), .LATENCY(2), .OFFSET(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_b     (rsp_b),
`ifdef INTF_RR_PARITY_EN
        .rsp_par   (rsp_par),
`endif
        .occupancy (occupancy),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic send(input logic [3:0] a);
        req_a     = a;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid, checks payload, then lets the handshake edge pass.
    task automatic expect_rsp(input string tag, input logic [3:0] exp_b);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_b"}, 32'(rsp_b), 32'(exp_b));
        @(negedge clk);
    endtask

    // Holds req_valid with value a until it is accepted (bounded).
    task automatic offer(input logic [3:0] a, output logic accepted);
        int n = 0;
        logic acc;
        req_a     = a;
        req_valid = 1'b1;
        do begin
            acc = req_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 30);
        req_valid = 1'b0;
        accepted  = acc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_seq [6];
        logic       acc;
        int         idx;
        int         seen;
        logic       six_taken;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        rsp_ready = 1'b0;

        // Asynchronous reset asserted between edges.
        #3 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_b", 32'(rsp_b), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request: accepted at E0, response valid after E3, one-cycle pulse.
        rsp_ready = 1'b1;
        send(4'd5);
        check("single_occ_e0", 32'(occupancy), 32'd1);
        check("single_busy_e0", 32'(busy), 32'd0);
        @(negedge clk);
        check("single_busy_e1", 32'(busy), 32'd1);
        check("single_occ_e1", 32'(occupancy), 32'd0);
        check("single_valid_e1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_valid_e2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_valid_e3", 32'(rsp_valid), 32'd1);
        check("single_b_e3", 32'(rsp_b), 32'd8);
        @(negedge clk);
        check("single_valid_e4", 32'(rsp_valid), 32'd0);
        check("single_busy_e4", 32'(busy), 32'd0);

        // Wrapping add.
        send(4'd14);
        expect_rsp("wrap14", 4'd1);
        send(4'd13);
        expect_rsp("wrap13", 4'd0);

        // Backpressure: 1 in work, 2..5 fill the FIFO, 6 refused.
        rsp_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            offer(4'(v), acc);
            check($sformatf("bp_accept_%0d", v), 32'(acc), 32'd1);
        end
        req_a     = 4'd6;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_occ_full", 32'(occupancy), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_b_held", 32'(rsp_b), 32'd4);

        exp_seq   = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        idx       = 0;
        six_taken = 1'b0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && idx < 6; cyc++) begin
            if (req_valid && req_ready) six_taken = 1'b1;
            if (rsp_valid) begin
                check($sformatf("order_%0d", idx), 32'(rsp_b), 32'(exp_seq[idx]));
                idx++;
            end
            @(negedge clk);
            if (six_taken) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("order_count", 32'(idx), 32'd6);
        @(negedge clk);

        // Stable hold for 10 cycles, handshake on the 11th.
        rsp_ready = 1'b0;
        send(4'd7);
        seen = 0;
        while (rsp_valid !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("hold_b_%0d", i), 32'(rsp_b), 32'd10);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("hold_valid_11", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("hold_released", 32'(rsp_valid), 32'd0);
        @(negedge clk);

        // Reset in RESP with three requests queued.
        rsp_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            offer(4'(v), acc);
        end
        seen = 0;
        while (rsp_valid !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("mid_occ", 32'(occupancy), 32'd3);
        check("mid_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_b", 32'(rsp_b), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("post_rst_quiet", 32'(seen), 32'd0);
        check("post_rst_occ", 32'(occupancy), 32'd0);

`ifdef INTF_RR_PARITY_EN
        send(4'd4);
        seen = 0;
        while (rsp_valid !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("par4_b", 32'(rsp_b), 32'd7);
        check("par4_par", 32'(rsp_par), 32'd1);
        @(negedge clk);
        send(4'd0);
        seen = 0;
        while (rsp_valid !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("par0_b", 32'(rsp_b), 32'd3);
        check("par0_par", 32'(rsp_par), 32'd0);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
